// File: rtl/ecg_argmax_sched_pkg.sv
// ecg_argmax_sched_pkg: shared state encoding, lane constants and lane index helpers
package ecg_argmax_sched_pkg;
  localparam int DEF_DATA_W = 10;
  localparam int DEF_N_LANE = 7;
  localparam logic [DEF_DATA_W-1:0] LANE_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};
  typedef enum logic [1:0] {FILL, CMP, RES, DONE} state_e;
  function automatic int lane_lsb(input int lane, input int n_lane, input int data_w);
    return (n_lane - 1 - lane) * data_w;
  endfunction
endpackage

// File: rtl/ecg_lane_first_match.sv
// ecg_lane_first_match: lowest lane index whose value equals max_i (lanes_i lane 0 at MSBs) -> idx_o
module ecg_lane_first_match
  import ecg_argmax_sched_pkg::*;
#(
  parameter int N_LANE = DEF_N_LANE,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [N_LANE*DATA_W-1:0] lanes_i,
  input  logic [DATA_W-1:0]        max_i,
  output logic [2:0]               idx_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N_LANE - 1; i >= 0; i--)
      idx_o = lanes_i[lane_lsb(i, N_LANE, DATA_W) +: DATA_W] == max_i ? 3'(i) : idx_o;
  end
endmodule

// File: rtl/ecg_argmax_sched.sv
// ecg_argmax_sched: packs score stream into 7-lane compare passes, tracks running max/class, returns {class,max,err}
module ecg_argmax_sched
  import ecg_argmax_sched_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int N_LANE  = DEF_N_LANE,
  parameter int N_CLASS = 5,
  parameter int CLS_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     score_valid_i,
  input  logic [DATA_W-1:0]        score_data_i,
  input  logic                     score_last_i,
  output logic                     score_ready_o,
  output logic [N_LANE*DATA_W-1:0] cmp_data_o,
  input  logic [DATA_W-1:0]        cmp_max_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [CLS_W-1:0]         res_class_o,
  output logic [DATA_W-1:0]        res_max_o,
  output logic                     res_err_o
);
  localparam logic [DATA_W-1:0] LMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [N_LANE*DATA_W-1:0] ALL_MIN = {N_LANE{LMIN}};
  localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(N_CLASS - 1);
  state_e state_q;
  logic [2:0] lane_cnt_q, win;
  logic [CLS_W-1:0] cls_cnt_q, pass_base_q, run_idx_q, cand, best_idx;
  logic [DATA_W-1:0] run_max_q, best_max;
  logic fend_q, err_q, accept, fend, full, take;
  assign accept = state_q == FILL && score_valid_i && score_ready_o;
  assign fend = score_last_i || cls_cnt_q == LAST_CLS;
  assign full = lane_cnt_q == 3'(N_LANE - 1);
  assign cand = pass_base_q + CLS_W'(win);
  // pass_base 0 marks the first pass; strict > keeps the earlier class on ties
  assign take = pass_base_q == '0 || $signed(cmp_max_i) > $signed(run_max_q);
  assign best_idx = take ? cand : run_idx_q;
  assign best_max = take ? cmp_max_i : run_max_q;
  ecg_lane_first_match #(.N_LANE(N_LANE), .DATA_W(DATA_W)) u_match (
    .lanes_i(cmp_data_o),
    .max_i  (cmp_max_i),
    .idx_o  (win)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= FILL;
      score_ready_o <= 1'b0;
      cmp_data_o <= ALL_MIN;
      lane_cnt_q <= '0;
      cls_cnt_q <= '0;
      pass_base_q <= '0;
      run_idx_q <= '0;
      run_max_q <= '0;
      fend_q <= 1'b0;
      err_q <= 1'b0;
      res_valid_o <= 1'b0;
      res_class_o <= '0;
      res_max_o <= '0;
      res_err_o <= 1'b0;
    end else case (state_q)
      FILL: begin
        score_ready_o <= !(accept && (fend || full));
        if (accept) begin
          cmp_data_o[lane_lsb(int'(lane_cnt_q), N_LANE, DATA_W) +: DATA_W] <= score_data_i;
          lane_cnt_q <= lane_cnt_q + 3'd1;
          cls_cnt_q <= cls_cnt_q + CLS_W'(1);
          fend_q <= fend;
          err_q <= score_last_i != (cls_cnt_q == LAST_CLS);
          if (fend || full) state_q <= CMP;
        end
      end
      CMP: state_q <= RES;
      RES: begin
        run_max_q <= best_max;
        run_idx_q <= best_idx;
        if (fend_q) begin
          res_class_o <= best_idx;
          res_max_o <= best_max;
          res_err_o <= err_q;
          res_valid_o <= 1'b1;
          state_q <= DONE;
        end else begin
          pass_base_q <= pass_base_q + CLS_W'(N_LANE);
          cmp_data_o <= ALL_MIN;
          lane_cnt_q <= '0;
          score_ready_o <= 1'b1;
          state_q <= FILL;
        end
      end
      DONE: if (res_ready_i) begin
        res_valid_o <= 1'b0;
        cmp_data_o <= ALL_MIN;
        lane_cnt_q <= '0;
        cls_cnt_q <= '0;
        pass_base_q <= '0;
        score_ready_o <= 1'b1;
        state_q <= FILL;
      end
      default: state_q <= FILL;
    endcase
endmodule

// File: tb/tb_ecg_argmax_sched.sv
// tb_ecg_argmax_sched: scoreboard bench for 5-class and 12-class scheduler instances with a behavioural compare unit
module tb_ecg_argmax_sched;
  import ecg_argmax_sched_pkg::*;
  typedef struct packed {
    logic [4:0] cls;
    logic [9:0] mx;
    logic       err;
  } res_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst[2], score_valid[2], score_last[2], score_ready[2], res_valid[2], res_ready[2], res_err[2];
  logic [9:0] score_data[2], cmp_max[2], res_max[2];
  logic [4:0] res_class[2];
  logic [69:0] cmp_data[2];
  logic [69:0] allmin;
  res_t sbq[2][$];
  int checks = 0, errors = 0;
  int s[$];

  ecg_argmax_sched #(.N_CLASS(5)) dut5 (
    .clk(clk), .rst(rst[0]), .score_valid_i(score_valid[0]), .score_data_i(score_data[0]),
    .score_last_i(score_last[0]), .score_ready_o(score_ready[0]), .cmp_data_o(cmp_data[0]),
    .cmp_max_i(cmp_max[0]), .res_valid_o(res_valid[0]), .res_ready_i(res_ready[0]),
    .res_class_o(res_class[0]), .res_max_o(res_max[0]), .res_err_o(res_err[0])
  );
  ecg_argmax_sched #(.N_CLASS(12)) dut12 (
    .clk(clk), .rst(rst[1]), .score_valid_i(score_valid[1]), .score_data_i(score_data[1]),
    .score_last_i(score_last[1]), .score_ready_o(score_ready[1]), .cmp_data_o(cmp_data[1]),
    .cmp_max_i(cmp_max[1]), .res_valid_o(res_valid[1]), .res_ready_i(res_ready[1]),
    .res_class_o(res_class[1]), .res_max_o(res_max[1]), .res_err_o(res_err[1])
  );

  function automatic logic [9:0] lanes_max(input logic [69:0] w);
    logic [9:0] m;
    m = w[69:60];
    for (int i = 1; i < 7; i++) if ($signed(w[(6-i)*10 +: 10]) > $signed(m)) m = w[(6-i)*10 +: 10];
    return m;
  endfunction

  always_ff @(posedge clk) begin
    cmp_max[0] <= lanes_max(cmp_data[0]);
    cmp_max[1] <= lanes_max(cmp_data[1]);
  end

  function automatic res_t model(input int q[$], input int ncls, input bit last);
    res_t r;
    int bi;
    bi = 0;
    for (int i = 1; i < q.size(); i++) if (q[i] > q[bi]) bi = i;
    r.cls = 5'(bi);
    r.mx = 10'(q[bi]);
    r.err = last ? (q.size() != ncls) : 1'b1;
    return r;
  endfunction

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int d);
    check("rst_score_ready", score_ready[d], 0);
    check("rst_res_valid", res_valid[d], 0);
    check("rst_res_class", res_class[d], 0);
    check("rst_res_max", res_max[d], 0);
    check("rst_res_err", res_err[d], 0);
    check("rst_cmp_data", cmp_data[d], allmin);
  endtask

  task automatic send(input int d, input int v, input bit last);
    int t;
    t = 0;
    score_valid[d] = 1'b1;
    score_data[d] = 10'(v);
    score_last[d] = last;
    while (!score_ready[d] && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept", score_ready[d], 1);
    @(negedge clk);
    score_valid[d] = 1'b0;
    score_last[d] = 1'b0;
  endtask

  task automatic send_frame(input int d, input int q[$], input bit last, input bit stall_chk);
    sbq[d].push_back(model(q, d ? 12 : 5, last));
    foreach (q[i]) begin
      send(d, q[i], last && i == q.size() - 1);
      if (stall_chk && i == 6) begin
        check("stall_cycle1", score_ready[d], 0);
        @(negedge clk);
        check("stall_cycle2", score_ready[d], 0);
      end
    end
  endtask

  task automatic wait_drain(input int d);
    for (int t = 0; t < 200 && sbq[d].size() != 0; t++) @(negedge clk);
    check("drain", sbq[d].size(), 0);
  endtask

  always begin
    res_t e;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      if (!rst[d] && res_valid[d] && res_ready[d]) begin
        if (sbq[d].size() == 0) check("unexpected_result", res_valid[d], 0);
        else begin
          e = sbq[d].pop_front();
          check("res_class", res_class[d], e.cls);
          check("res_max", res_max[d], e.mx);
          check("res_err", res_err[d], e.err);
        end
      end
  end

  initial begin
    allmin = {7{LANE_MIN}};
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      score_valid[d] = 1'b0;
      score_data[d] = '0;
      score_last[d] = 1'b0;
      res_ready[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    s = '{3, -7, 120, 45, 120};
    send_frame(0, s, 1, 0);
    check("lanes56_pad", cmp_data[0][19:0], {LANE_MIN, LANE_MIN});
    check("lanes0to4", cmp_data[0][69:20], {10'(3), 10'(-7), 10'(120), 10'(45), 10'(120)});
    check("lat_e0", res_valid[0], 0);
    @(negedge clk);
    check("lat_e1", res_valid[0], 0);
    @(negedge clk);
    check("lat_e2", res_valid[0], 1);
    wait_drain(0);
    s = '{5, -3, 17, 0, 200, 1, 2, 9, -100, 200, 11, 6};
    send_frame(1, s, 1, 1);
    wait_drain(1);
    s = '{5, -3, 17, 0, 150, 1, 2, 9, -100, 200, 11, 6};
    send_frame(1, s, 1, 1);
    wait_drain(1);
    s = '{-512, -512, -512, -512, -512};
    send_frame(0, s, 1, 0);
    wait_drain(0);
    s = '{10, 50, 20};
    send_frame(0, s, 1, 0);
    wait_drain(0);
    s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, -1};
    send_frame(1, s, 0, 0);
    wait_drain(1);
    res_ready[0] = 1'b0;
    s = '{10, 20, 5, 1, 0};
    send_frame(0, s, 1, 0);
    for (int t = 0; t < 20 && !res_valid[0]; t++) @(negedge clk);
    score_valid[0] = 1'b1;
    score_data[0] = 10'd77;
    for (int k = 0; k < 6; k++) begin
      check("hold_valid", res_valid[0], 1);
      check("hold_class", res_class[0], 1);
      check("hold_max", res_max[0], 20);
      check("hold_ready", score_ready[0], 0);
      @(negedge clk);
    end
    res_ready[0] = 1'b1;
    @(negedge clk);
    check("ready_after_hs", score_ready[0], 1);
    check("valid_after_hs", res_valid[0], 0);
    score_valid[0] = 1'b0;
    s = '{-5, -1, -300, -1, -2};
    send_frame(0, s, 1, 0);
    wait_drain(0);
    for (int i = 0; i < 9; i++) send(1, i * 3, 0);
    rst[1] = 1'b1;
    @(negedge clk);
    check_reset(1);
    rst[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("no_result_after_rst", res_valid[1], 0);
    s = '{4, 8, -2, 8, 1};
    send_frame(1, s, 1, 0);
    wait_drain(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
